// File: rtl/first_last_capture.sv
// Frame capture: records first byte, last byte and beat count of each framed
// stream and publishes {first, last} to the four-digit hex display decoder.
module first_last_capture #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                hold,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_last,
    output logic [2*DATA_W-1:0] disp_word,
    output logic [CNT_W-1:0]    frame_len,
    output logic                len_sat,
    output logic                frame_done,
    output logic                drop_seen
);

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        PUBLISH
    } stateT;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    stateT             state;
    stateT             nextState;
    logic [DATA_W-1:0] firstByte;
    logic [DATA_W-1:0] lastByte;
    logic [CNT_W-1:0]  beatCount;
    logic              accept;

    // A beat offered in the same cycle as clear is discarded with the frame.
    assign accept = in_valid & in_ready & ~clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        if (clear) begin
            nextState = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) nextState = in_last ? PUBLISH : FRAME;
                FRAME:   if (accept && in_last) nextState = PUBLISH;
                PUBLISH: nextState = IDLE;
                default: nextState = IDLE;
            endcase
        end
    end

    // The publish cycle is the one bubble per frame; ready depends on state only.
    always_comb begin
        in_ready = (state != PUBLISH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            firstByte <= '0;
            lastByte  <= '0;
            beatCount <= '0;
        end else if (clear) begin
            firstByte <= '0;
            lastByte  <= '0;
            beatCount <= '0;
        end else if (accept) begin
            lastByte <= in_data;
            if (state == IDLE) begin
                firstByte <= in_data;
                beatCount <= CNT_W'(1);
            end else if (beatCount != CNT_MAX) begin
                beatCount <= beatCount + 1'b1;
            end
        end
    end

    // Hold only matters in the publish cycle: the finished frame is either
    // shown or dropped, and a drop is remembered until clear or reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_word  <= '0;
            frame_len  <= '0;
            len_sat    <= 1'b0;
            frame_done <= 1'b0;
            drop_seen  <= 1'b0;
        end else if (clear) begin
            disp_word  <= '0;
            frame_len  <= '0;
            len_sat    <= 1'b0;
            frame_done <= 1'b0;
            drop_seen  <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (state == PUBLISH) begin
                if (hold) begin
                    drop_seen <= 1'b1;
                end else begin
                    disp_word  <= {firstByte, lastByte};
                    frame_len  <= beatCount;
                    len_sat    <= (beatCount == CNT_MAX);
                    frame_done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_first_last_capture.sv
// Self-checking bench for first_last_capture: directed frames plus a random
// stress run compared against a queue-based frame model.
module tb_first_last_capture;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    logic                clk      = 1'b0;
    logic                rst_n    = 1'b0;
    logic                clear    = 1'b0;
    logic                hold     = 1'b0;
    logic                in_valid = 1'b0;
    logic [DATA_W-1:0]   in_data  = '0;
    logic                in_last  = 1'b0;
    logic                in_ready;
    logic [2*DATA_W-1:0] disp_word;
    logic [CNT_W-1:0]    frame_len;
    logic                len_sat;
    logic                frame_done;
    logic                drop_seen;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes of the frame in flight plus the expected outputs.
    logic [7:0]  frameBytes[$];
    bit          modelBusy = 1'b0;
    logic [15:0] expDisp   = '0;
    logic [7:0]  expLen    = '0;
    logic        expSat    = 1'b0;
    logic        expDone   = 1'b0;
    logic        expDrop   = 1'b0;

    always #5 clk = ~clk;

    first_last_capture #(
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .hold      (hold),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .disp_word (disp_word),
        .frame_len (frame_len),
        .len_sat   (len_sat),
        .frame_done(frame_done),
        .drop_seen (drop_seen)
    );

    task automatic modelReset();
        frameBytes.delete();
        modelBusy = 1'b0;
        expDisp   = '0;
        expLen    = '0;
        expSat    = 1'b0;
        expDone   = 1'b0;
        expDrop   = 1'b0;
    endtask

    // One clock edge of the frame rules, applied to the current inputs.
    task automatic modelEdge();
        if (clear) begin
            modelReset();
        end else if (modelBusy) begin
            modelBusy = 1'b0;
            expDone   = 1'b0;
            if (hold) begin
                expDrop = 1'b1;
            end else begin
                expDisp = {frameBytes[0], frameBytes[$]};
                expLen  = (frameBytes.size() >= 255) ? 8'd255 : 8'(frameBytes.size());
                expSat  = (frameBytes.size() >= 255);
                expDone = 1'b1;
            end
            frameBytes.delete();
        end else begin
            expDone = 1'b0;
            if (in_valid) begin
                frameBytes.push_back(in_data);
                if (in_last) modelBusy = 1'b1;
            end
        end
    endtask

    task automatic checkValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".in_ready"},   {31'b0, in_ready},   {31'b0, !modelBusy});
        checkValue({tag, ".disp_word"},  {16'b0, disp_word},  {16'b0, expDisp});
        checkValue({tag, ".frame_len"},  {24'b0, frame_len},  {24'b0, expLen});
        checkValue({tag, ".len_sat"},    {31'b0, len_sat},    {31'b0, expSat});
        checkValue({tag, ".frame_done"}, {31'b0, frame_done}, {31'b0, expDone});
        checkValue({tag, ".drop_seen"},  {31'b0, drop_seen},  {31'b0, expDrop});
    endtask

    // Drive one cycle of inputs, advance model and DUT one edge, then compare.
    task automatic applyStimulus(input bit v, input logic [7:0] d, input bit l,
                                 input bit h, input bit c, output bit accepted);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        hold     = h;
        clear    = c;
        accepted = v && !modelBusy && !c;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("step");
    endtask

    task automatic sendFrame(input logic [7:0] bytes[$], input int gapPct,
                             input bit holdVal, input bit trailIdle);
        bit acc;
        int budget;
        foreach (bytes[i]) begin
            budget = 0;
            acc    = 1'b0;
            while (!acc && budget < 20) begin
                if ($urandom_range(99) < gapPct)
                    applyStimulus(1'b0, 8'($urandom), 1'b1, holdVal, 1'b0, acc);
                applyStimulus(1'b1, bytes[i], (i == bytes.size() - 1), holdVal, 1'b0, acc);
                budget++;
            end
            checks++;
            assert (acc)
            else begin
                errors++;
                $error("[TB] FAIL beatTimeout observed=notAccepted expected=accepted");
            end
        end
        if (trailIdle) applyStimulus(1'b0, 8'h00, 1'b0, holdVal, 1'b0, acc);
    endtask

    initial begin
        logic [7:0] bytes[$];
        bit acc;

        // Reset values while rst_n is low.
        #13;
        modelReset();
        checkOutput("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] four-beat frame");
        bytes = '{8'h12, 8'h34, 8'h56, 8'h78};
        sendFrame(bytes, 0, 1'b0, 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        checkValue("frame4.disp", {16'b0, disp_word}, 32'h1278);
        checkValue("frame4.len",  {24'b0, frame_len}, 32'd4);
        checkValue("frame4.sat",  {31'b0, len_sat},   32'd0);

        $display("[TB] single-beat frame");
        bytes = '{8'hA5};
        sendFrame(bytes, 0, 1'b0, 1'b1);
        checkValue("single.disp", {16'b0, disp_word}, 32'hA5A5);
        checkValue("single.len",  {24'b0, frame_len}, 32'd1);

        $display("[TB] frame under hold");
        bytes = '{8'h01, 8'h02, 8'h03};
        sendFrame(bytes, 0, 1'b1, 1'b1);
        checkValue("hold.disp", {16'b0, disp_word}, 32'hA5A5);
        checkValue("hold.drop", {31'b0, drop_seen}, 32'd1);
        bytes = '{8'hC0, 8'hDE};
        sendFrame(bytes, 0, 1'b0, 1'b1);
        checkValue("afterHold.disp", {16'b0, disp_word}, 32'hC0DE);
        checkValue("afterHold.drop", {31'b0, drop_seen}, 32'd1);

        $display("[TB] 300-beat saturating frame");
        bytes.delete();
        bytes.push_back(8'h11);
        for (int i = 0; i < 298; i++) bytes.push_back(8'($urandom));
        bytes.push_back(8'hEF);
        sendFrame(bytes, 30, 1'b0, 1'b1);
        checkValue("long.disp", {16'b0, disp_word}, 32'h11EF);
        checkValue("long.len",  {24'b0, frame_len}, 32'd255);
        checkValue("long.sat",  {31'b0, len_sat},   32'd1);

        $display("[TB] clear mid-frame");
        applyStimulus(1'b1, 8'h21, 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'h99, 1'b1, 1'b0, 1'b1, acc);
        checkValue("clear.disp", {16'b0, disp_word}, 32'h0);
        checkValue("clear.len",  {24'b0, frame_len}, 32'h0);
        checkValue("clear.drop", {31'b0, drop_seen}, 32'h0);
        bytes = '{8'hBE, 8'hEF};
        sendFrame(bytes, 0, 1'b0, 1'b1);
        checkValue("postClear.disp", {16'b0, disp_word}, 32'hBEEF);
        checkValue("postClear.len",  {24'b0, frame_len}, 32'd2);

        $display("[TB] reset mid-frame");
        applyStimulus(1'b1, 8'h31, 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'h32, 1'b0, 1'b0, 1'b0, acc);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #2;
        modelReset();
        checkOutput("asyncReset");
        checkValue("asyncReset.disp", {16'b0, disp_word}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bytes = '{8'hBE, 8'hEF};
        sendFrame(bytes, 0, 1'b0, 1'b1);
        checkValue("postReset.disp", {16'b0, disp_word}, 32'hBEEF);
        checkValue("postReset.len",  {24'b0, frame_len}, 32'd2);

        $display("[TB] random stress");
        for (int f = 0; f < 1000; f++) begin
            bytes.delete();
            for (int b = 0; b < int'($urandom_range(1, 6)); b++) bytes.push_back(8'($urandom));
            sendFrame(bytes, 25, ($urandom_range(9) == 0), ($urandom_range(3) == 0));
            if ($urandom_range(49) == 0)
                applyStimulus(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b1, acc);
        end
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, acc);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
